// File: rtl/branch_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_stack_unit
// Purpose  : PC sequencer resolving JMP/BEQ/BNE/BLT/CALL/RET with a return stack.
// Revision : 1.0 - initial release
// ============================================================================
module branch_stack_unit #(
  parameter int DATA_W      = 19,
  parameter int ADDR_W      = 15,
  parameter int OP_W        = 4,
  parameter int STACK_DEPTH = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] TRAP_VEC = DATA_W'(1),
  localparam int PTR_W = $clog2(STACK_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] reg1_data,
  input  logic [DATA_W-1:0] reg2_data,
  input  logic              clr_fault,
  output logic [DATA_W-1:0] pc,
  output logic              branch_taken,
  output logic [PTR_W:0]    stack_count,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              fault_ovf,
  output logic              fault_unf
);

  localparam logic [OP_W-1:0] c_OP_JMP  = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] c_OP_BEQ  = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] c_OP_BNE  = OP_W'(4'b0011);
  localparam logic [OP_W-1:0] c_OP_CALL = OP_W'(4'b0100);
  localparam logic [OP_W-1:0] c_OP_RET  = OP_W'(4'b0101);
  localparam logic [OP_W-1:0] c_OP_BLT  = OP_W'(4'b0110);
  localparam logic [PTR_W:0]  c_FULL    = (PTR_W+1)'(STACK_DEPTH);

  logic [DATA_W-1:0] r_pc;
  logic              r_taken;
  logic [PTR_W:0]    r_count;
  logic              r_ovf;
  logic              r_unf;
  logic [DATA_W-1:0] r_stack [STACK_DEPTH];

  logic              w_advance;
  logic [OP_W-1:0]   w_op;
  logic [DATA_W-1:0] w_tgt;
  logic [DATA_W-1:0] w_seq;
  logic [DATA_W-1:0] w_next_pc;
  logic              w_taken;
  logic              w_push;
  logic              w_pop;
  logic              w_set_ovf;
  logic              w_set_unf;
  logic              w_full;
  logic              w_empty;
  logic [PTR_W-1:0]  w_push_idx;
  logic [PTR_W-1:0]  w_pop_idx;

  assign w_advance  = instr_valid & ~stall;
  assign w_op       = instruction[DATA_W-1 -: OP_W];
  assign w_tgt      = {{(DATA_W-ADDR_W){1'b0}}, instruction[ADDR_W-1:0]};
  assign w_seq      = r_pc + DATA_W'(1);
  assign w_full     = (r_count == c_FULL);
  assign w_empty    = (r_count == '0);
  assign w_push_idx = r_count[PTR_W-1:0];
  assign w_pop_idx  = PTR_W'(r_count - (PTR_W+1)'(1));

  always_comb begin
    w_next_pc = w_seq;
    w_taken   = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (w_advance) begin
      case (w_op)
        c_OP_JMP: begin
          w_next_pc = w_tgt;
          w_taken   = 1'b1;
        end
        c_OP_BEQ: begin
          if (reg1_data == reg2_data) begin
            w_next_pc = w_tgt;
            w_taken   = 1'b1;
          end
        end
        c_OP_BNE: begin
          if (reg1_data != reg2_data) begin
            w_next_pc = w_tgt;
            w_taken   = 1'b1;
          end
        end
        c_OP_BLT: begin
          if ($signed(reg1_data) < $signed(reg2_data)) begin
            w_next_pc = w_tgt;
            w_taken   = 1'b1;
          end
        end
        c_OP_CALL: begin
          w_taken = 1'b1;
          if (w_full) begin
            w_set_ovf = 1'b1;
            w_next_pc = TRAP_VEC;
          end else begin
            w_push    = 1'b1;
            w_next_pc = w_tgt;
          end
        end
        c_OP_RET: begin
          w_taken = 1'b1;
          if (w_empty) begin
            w_set_unf = 1'b1;
            w_next_pc = TRAP_VEC;
          end else begin
            w_pop     = 1'b1;
            w_next_pc = r_stack[w_pop_idx];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_taken <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_advance) begin
        r_pc    <= w_next_pc;
        r_taken <= w_taken;
        if (w_push) r_count <= r_count + (PTR_W+1)'(1);
        else if (w_pop) r_count <= r_count - (PTR_W+1)'(1);
      end else begin
        r_taken <= 1'b0;
      end
      // A new fault on the same edge as a clear wins.
      if (w_set_ovf) r_ovf <= 1'b1;
      else if (clr_fault) r_ovf <= 1'b0;
      if (w_set_unf) r_unf <= 1'b1;
      else if (clr_fault) r_unf <= 1'b0;
    end
  end

  // Storage is deliberately unreset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (w_push && rst_n) r_stack[w_push_idx] <= w_seq;
  end

  assign pc           = r_pc;
  assign branch_taken = r_taken;
  assign stack_count  = r_count;
  assign stack_full   = w_full;
  assign stack_empty  = w_empty;
  assign fault_ovf    = r_ovf;
  assign fault_unf    = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_branch_stack_unit.sv
`default_nettype none
// Testbench for branch_stack_unit: queue-based reference model plus directed vectors.
module tb_branch_stack_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        stall;
  logic [18:0] instruction;
  logic [18:0] reg1_data;
  logic [18:0] reg2_data;
  logic        clr_fault;
  logic [18:0] pc;
  logic        branch_taken;
  logic [4:0]  stack_count;
  logic        stack_full;
  logic        stack_empty;
  logic        fault_ovf;
  logic        fault_unf;

  logic [18:0] w_pc;
  logic        w_taken;
  logic [4:0]  w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_ovf;
  logic        w_unf;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  branch_stack_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stall(stall),
    .instruction(instruction), .reg1_data(reg1_data), .reg2_data(reg2_data),
    .clr_fault(clr_fault), .pc(pc), .branch_taken(branch_taken),
    .stack_count(stack_count), .stack_full(stack_full), .stack_empty(stack_empty),
    .fault_ovf(fault_ovf), .fault_unf(fault_unf)
  );

  // Second instance starting at the top of the address space for the wrap case.
  branch_stack_unit #(.RESET_PC(19'h7FFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stall(stall),
    .instruction(instruction), .reg1_data(reg1_data), .reg2_data(reg2_data),
    .clr_fault(clr_fault), .pc(w_pc), .branch_taken(w_taken),
    .stack_count(w_count), .stack_full(w_full), .stack_empty(w_empty),
    .fault_ovf(w_ovf), .fault_unf(w_unf)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model
  logic [18:0] m_pc;
  bit          m_taken, m_ovf, m_unf;
  logic [18:0] m_stack[$];

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0]  op;
    logic [18:0] tgt, seq, nxt;
    bit tk, so, su;
    if (!rst_n) begin
      m_pc = 19'h0; m_taken = 0; m_ovf = 0; m_unf = 0;
      m_stack.delete();
    end else begin
      so = 0; su = 0;
      if (instr_valid && !stall) begin
        op  = instruction[18:15];
        tgt = {4'b0, instruction[14:0]};
        seq = m_pc + 19'd1;
        nxt = seq; tk = 0;
        case (op)
          4'h0: begin nxt = tgt; tk = 1; end
          4'h2: if (reg1_data == reg2_data) begin nxt = tgt; tk = 1; end
          4'h3: if (reg1_data != reg2_data) begin nxt = tgt; tk = 1; end
          4'h6: if ($signed(reg1_data) < $signed(reg2_data)) begin nxt = tgt; tk = 1; end
          4'h4: begin
            tk = 1;
            if (m_stack.size() < 16) begin m_stack.push_back(seq); nxt = tgt; end
            else begin so = 1; nxt = 19'd1; end
          end
          4'h5: begin
            tk = 1;
            if (m_stack.size() > 0) nxt = m_stack.pop_back();
            else begin su = 1; nxt = 19'd1; end
          end
          default: ;
        endcase
        m_pc = nxt; m_taken = tk;
      end else begin
        m_taken = 0;
      end
      if (so) m_ovf = 1; else if (clr_fault) m_ovf = 0;
      if (su) m_unf = 1; else if (clr_fault) m_unf = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", 32'(pc), 32'(m_pc));
      check("branch_taken", 32'(branch_taken), 32'(m_taken));
      check("stack_count", 32'(stack_count), 32'(m_stack.size()));
      check("stack_full", 32'(stack_full), 32'(m_stack.size() == 16));
      check("stack_empty", 32'(stack_empty), 32'(m_stack.size() == 0));
      check("fault_ovf", 32'(fault_ovf), 32'(m_ovf));
      check("fault_unf", 32'(fault_unf), 32'(m_unf));
    end
  end

  task automatic step(input bit v, input bit st, input logic [3:0] op, input logic [14:0] addr,
                      input logic [18:0] r1, input logic [18:0] r2, input bit clr);
    @(negedge clk);
    instr_valid = v; stall = st; instruction = {op, addr};
    reg1_data = r1; reg2_data = r2; clr_fault = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 0; stall = 0; instruction = '0;
    reg1_data = '0; reg2_data = '0; clr_fault = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    check("reset pc", 32'(pc), 32'h0);
    check("reset empty", 32'(stack_empty), 32'h1);
    check("reset faults", 32'({fault_ovf, fault_unf}), 32'h0);
    check("reset taken", 32'(branch_taken), 32'h0);
    check("wrap reset pc", 32'(w_pc), 32'h7FFFF);

    step(1, 0, 4'h1, 15'h0, 0, 0, 0);
    check("nop pc", 32'(pc), 32'h1);
    check("wrap pc", 32'(w_pc), 32'h0);
    check("wrap taken", 32'(w_taken), 32'h0);

    step(1, 0, 4'h0, 15'h5, 0, 0, 0);
    check("jmp5 pc", 32'(pc), 32'h5);
    step(1, 1, 4'h0, 15'h1234, 0, 0, 0);
    check("stall pc", 32'(pc), 32'h5);
    check("stall taken", 32'(branch_taken), 32'h0);
    step(1, 0, 4'h0, 15'h1234, 0, 0, 0);
    check("jmp pc", 32'(pc), 32'h01234);
    check("jmp taken", 32'(branch_taken), 32'h1);
    step(0, 0, 4'h0, 15'h0, 0, 0, 0);
    check("pulse end", 32'(branch_taken), 32'h0);

    step(1, 0, 4'h3, 15'h40, 19'd7, 19'd7, 0);
    check("bne eq pc", 32'(pc), 32'h1235);
    check("bne eq taken", 32'(branch_taken), 32'h0);
    step(1, 0, 4'h3, 15'h40, 19'd7, 19'd8, 0);
    check("bne ne pc", 32'(pc), 32'h40);
    step(1, 0, 4'h2, 15'h44, 19'd3, 19'd3, 0);
    check("beq pc", 32'(pc), 32'h44);
    step(1, 0, 4'h6, 15'h50, 19'h7FFFF, 19'd0, 0);
    check("blt neg pc", 32'(pc), 32'h50);
    step(1, 0, 4'h6, 15'h60, 19'd0, 19'h7FFFF, 0);
    check("blt pos pc", 32'(pc), 32'h51);

    step(1, 0, 4'h0, 15'h20, 0, 0, 0);
    step(1, 0, 4'h4, 15'h100, 0, 0, 0);
    check("call pc", 32'(pc), 32'h100);
    check("call count", 32'(stack_count), 32'h1);
    step(1, 0, 4'h5, 15'h0, 0, 0, 0);
    check("ret pc", 32'(pc), 32'h21);
    check("ret count", 32'(stack_count), 32'h0);

    step(1, 0, 4'h0, 15'h200, 0, 0, 0);
    for (int k = 0; k < 17; k++) step(1, 0, 4'h4, 15'(16'h300 + k), 0, 0, 0);
    check("ovf pc", 32'(pc), 32'h1);
    check("ovf count", 32'(stack_count), 32'd16);
    check("ovf full", 32'(stack_full), 32'h1);
    check("ovf flag", 32'(fault_ovf), 32'h1);
    for (int k = 0; k < 16; k++) step(1, 0, 4'h5, 15'h0, 0, 0, 0);
    check("unwind pc", 32'(pc), 32'h201);
    check("unwind empty", 32'(stack_empty), 32'h1);
    step(1, 0, 4'h5, 15'h0, 0, 0, 0);
    check("unf pc", 32'(pc), 32'h1);
    check("unf flag", 32'(fault_unf), 32'h1);
    check("ovf sticky", 32'(fault_ovf), 32'h1);
    step(1, 0, 4'h1, 15'h0, 0, 0, 1);
    check("clr faults", 32'({fault_ovf, fault_unf}), 32'h0);
    check("clr pc", 32'(pc), 32'h2);
    step(1, 0, 4'h5, 15'h0, 0, 0, 1);
    check("clr+unf", 32'(fault_unf), 32'h1);

    step(1, 0, 4'h4, 15'h10, 0, 0, 0);
    check("pre-rst count", 32'(stack_count), 32'h1);
    @(negedge clk);
    instr_valid = 1; stall = 1; instruction = {4'h4, 15'h30};
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async pc", 32'(pc), 32'h0);
    check("async count", 32'(stack_count), 32'h0);
    check("async taken", 32'(branch_taken), 32'h0);
    check("async unf", 32'(fault_unf), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; stall = 0; instr_valid = 0;
    step(1, 0, 4'h1, 15'h0, 0, 0, 0);
    check("post-rst pc", 32'(pc), 32'h1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
